hazard_stall_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage MIPS-Lite pipeline; sits beside the ID stage.

---
 rtl/hazard_stall_ctrl.sv | 101 ++++++++++
 tb/tb_hazard_stall_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer beside the ID stage: shadows destination registers in EX/MEM/WB,
// decides how many bubbles the decoding instruction needs and drives hold/bubble/flush.
module hazard_stall_ctrl #(
  parameter int REGISTERWIDTH = 5,
  parameter int FORWARDING    = 1,
  parameter int CNTWIDTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [REGISTERWIDTH-1:0] id_rs1,
  input  logic [REGISTERWIDTH-1:0] id_rs2,
  input  logic                     id_use_rs1,
  input  logic                     id_use_rs2,
  input  logic [REGISTERWIDTH-1:0] id_rd,
  input  logic                     id_writes,
  input  logic                     id_is_load,
  input  logic                     ex_branch_taken,
  output logic                     stall_pc,
  output logic                     stall_ifid,
  output logic                     bubble_idex,
  output logic                     flush_ifid,
  output logic [CNTWIDTH-1:0]      stall_cycles
);
  localparam int SLOTS = 3;  // 0 = EX, 1 = MEM, 2 = WB

  typedef struct packed {
    logic [REGISTERWIDTH-1:0] rd;
    logic                     ld;
  } slot_t;

  typedef enum logic {RUN, STALL} state_t;

  state_t                  state;
  logic [1:0]              cnt;
  logic [SLOTS-1:0]        vld_pipe;
  slot_t [SLOTS-1:0]       sb;
  logic [SLOTS-1:0]        hit;
  logic [SLOTS-1:0][1:0]   req;
  logic [1:0]              need;
  logic                    stall;
  logic                    enter;

  // A producer in slot s is usable after (lat - s) more cycles; WB always resolves to zero
  // because the register file is write-first.
  for (genvar s = 0; s < SLOTS; s++) begin : g_slot
    logic [1:0] lat;
    assign hit[s] = id_valid & vld_pipe[s] &
                    ((id_use_rs1 & (id_rs1 == sb[s].rd)) | (id_use_rs2 & (id_rs2 == sb[s].rd)));
    assign lat    = (FORWARDING == 0) ? 2'd2 : {1'b0, sb[s].ld};
    assign req[s] = (hit[s] && (lat > 2'(s))) ? (lat - 2'(s)) : 2'd0;
  end

  always_comb begin
    need = 2'd0;
    for (int s = 0; s < SLOTS; s++)
      if (req[s] > need) need = req[s];
  end

  always_comb begin
    stall = 1'b0;
    if (!ex_branch_taken) stall = (state == STALL) | (need != 2'd0);
  end

  assign stall_pc    = stall;
  assign stall_ifid  = stall;
  assign bubble_idex = stall | ex_branch_taken;
  assign flush_ifid  = ex_branch_taken;
  assign enter       = id_valid & id_writes & (id_rd != '0) & ~stall & ~ex_branch_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      cnt          <= 2'd0;
      vld_pipe     <= '0;
      sb           <= '0;
      stall_cycles <= '0;
    end else begin
      vld_pipe <= {vld_pipe[SLOTS-2:0], enter};
      sb[2:1]  <= sb[1:0];
      sb[0]    <= '{rd: id_rd, ld: id_is_load};
      if (stall && !(&stall_cycles)) stall_cycles <= stall_cycles + CNTWIDTH'(1);
      if (ex_branch_taken) begin
        state <= RUN;
        cnt   <= 2'd0;
      end else begin
        case (state)
          RUN: if (need == 2'd2) begin
            state <= STALL;
            cnt   <= 2'd1;
          end
          STALL: begin
            cnt <= cnt - 2'd1;
            if (cnt == 2'd1) state <= RUN;
          end
          default: state <= RUN;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomized scoreboard bench: one instance without forwarding, one with forwarding and a
// narrow counter; a history-of-issued-writers model predicts every cycle's outputs.
module tb_hazard_stall_ctrl;
  typedef struct packed {
    logic v; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
    logic [4:0] rd; logic w; logic ld;
  } ins_t;

  typedef struct packed {
    logic spc; logic sif; logic bub; logic fl; logic [15:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  ins_t        din [2];
  logic        br [2];
  logic        rst [2];
  logic        spc [2], sif [2], bub [2], fl [2];
  logic [15:0] cyc0;
  logic [3:0]  cyc1;

  exp_t q0[$], q1[$];
  int   checks = 0, passed = 0;

  // model: last three pipeline entries after ID, index 0 nearest
  logic       hv  [2][3];
  logic [4:0] hrd [2][3];
  logic       hld [2][3];
  int         hold [2];
  int         sc [2];

  hazard_stall_ctrl #(.REGISTERWIDTH(5), .FORWARDING(0), .CNTWIDTH(16)) dut0 (
    .clk(clk), .rst(rst[0]), .id_valid(din[0].v), .id_rs1(din[0].rs1), .id_rs2(din[0].rs2),
    .id_use_rs1(din[0].u1), .id_use_rs2(din[0].u2), .id_rd(din[0].rd), .id_writes(din[0].w),
    .id_is_load(din[0].ld), .ex_branch_taken(br[0]), .stall_pc(spc[0]), .stall_ifid(sif[0]),
    .bubble_idex(bub[0]), .flush_ifid(fl[0]), .stall_cycles(cyc0));

  hazard_stall_ctrl #(.REGISTERWIDTH(5), .FORWARDING(1), .CNTWIDTH(4)) dut1 (
    .clk(clk), .rst(rst[1]), .id_valid(din[1].v), .id_rs1(din[1].rs1), .id_rs2(din[1].rs2),
    .id_use_rs1(din[1].u1), .id_use_rs2(din[1].u2), .id_rd(din[1].rd), .id_writes(din[1].w),
    .id_is_load(din[1].ld), .ex_branch_taken(br[1]), .stall_pc(spc[1]), .stall_ifid(sif[1]),
    .bubble_idex(bub[1]), .flush_ifid(fl[1]), .stall_cycles(cyc1));

  function automatic ins_t mk(int a, int ua, int b, int ub, int d, int w, int l);
    ins_t i;
    i.v = 1'b1; i.rs1 = 5'(a); i.u1 = ua[0]; i.rs2 = 5'(b); i.u2 = ub[0];
    i.rd = 5'(d); i.w = w[0]; i.ld = l[0];
    return i;
  endfunction

  // Instance 0: a result is readable once its producer reaches WB (distance 3 from ID).
  // Instance 1: only a load one stage ahead costs a cycle.
  task automatic drive(input int k, input ins_t i, input logic b, input logic r, output logic st);
    int   near, req;
    logic s;
    exp_t e;
    @(negedge clk);
    din[k] = i; br[k] = b; rst[k] = r;
    st = 1'b0;
    if (r) begin
      for (int j = 0; j < 3; j++) hv[k][j] = 1'b0;
      hold[k] = 0; sc[k] = 0;
      return;
    end
    near = 3;
    if (i.v)
      for (int j = 2; j >= 0; j--)
        if (hv[k][j] && ((i.u1 && i.rs1 == hrd[k][j]) || (i.u2 && i.rs2 == hrd[k][j]))) near = j;
    if (k == 0) req = (near < 2) ? 2 - near : 0;
    else        req = (near == 0 && hld[k][0]) ? 1 : 0;
    if (b)                begin s = 1'b0; hold[k] = 0; end
    else if (hold[k] > 0) begin s = 1'b1; hold[k] = hold[k] - 1; end
    else                  begin s = (req > 0); hold[k] = (req == 2) ? 1 : 0; end
    e.spc = s; e.sif = s; e.bub = s | b; e.fl = b; e.cyc = 16'(sc[k]);
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    if (s && sc[k] < ((k == 0) ? 65535 : 15)) sc[k] = sc[k] + 1;
    for (int j = 2; j > 0; j--) begin
      hv[k][j] = hv[k][j-1]; hrd[k][j] = hrd[k][j-1]; hld[k][j] = hld[k][j-1];
    end
    hv[k][0]  = i.v && i.w && (i.rd != 5'd0) && !s && !b;
    hrd[k][0] = i.rd;
    hld[k][0] = i.ld;
    st = s;
  endtask

  // present an instruction until the model says it issues
  task automatic issue(input int k, input ins_t i);
    logic st;
    int   n;
    n = 0;
    do begin
      drive(k, i, 1'b0, 1'b0, st);
      n++;
    end while (st && n < 4);
    if (st) begin
      checks++;
      $display("FAIL issue_bound inst%0d: still stalled after %0d cycles, required release", k, n);
    end
  endtask

  task automatic prog(input int k);
    logic st;
    ins_t nop, x, cons;
    nop = '0;
    drive(k, nop, 1'b0, 1'b1, st);
    drive(k, nop, 1'b0, 1'b1, st);
    for (int gap = 0; gap < 3; gap++) begin
      issue(k, mk(1, 1, 2, 1, 3, 1, 0));
      for (int g = 0; g < gap; g++) issue(k, nop);
      issue(k, mk(3, 1, 4, 0, 6, 1, 0));
      repeat (3) issue(k, nop);
    end
    issue(k, mk(7, 1, 0, 0, 5, 1, 1)); issue(k, mk(5, 1, 5, 1, 8, 1, 0)); repeat (3) issue(k, nop);
    issue(k, mk(7, 1, 0, 0, 5, 1, 0)); issue(k, mk(2, 0, 5, 1, 8, 1, 0)); repeat (3) issue(k, nop);
    issue(k, mk(1, 1, 1, 1, 0, 1, 1)); issue(k, mk(0, 1, 0, 1, 9, 1, 0)); repeat (3) issue(k, nop);
    // taken branch while the consumer is stalled
    cons = mk(3, 1, 0, 0, 6, 1, 0);
    issue(k, mk(1, 1, 2, 1, 3, 1, 0));
    drive(k, cons, 1'b0, 1'b0, st);
    drive(k, cons, 1'b1, 1'b0, st);
    repeat (3) issue(k, nop);
    // reset while the consumer is stalled; the producer is forgotten afterwards
    issue(k, mk(1, 1, 2, 1, 3, 1, 1));
    drive(k, cons, 1'b0, 1'b0, st);
    drive(k, cons, 1'b0, 1'b1, st);
    drive(k, cons, 1'b0, 1'b0, st);
    repeat (3) issue(k, nop);
    // enough load-use stalls to pin the narrow counter at all-ones
    repeat (20) begin
      issue(k, mk(7, 1, 0, 0, 5, 1, 1));
      issue(k, mk(5, 1, 0, 0, 8, 1, 0));
    end
    x = nop; st = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (!(st && $urandom_range(0, 7) != 0)) begin
        x.v   = ($urandom_range(0, 9) < 8);
        x.rs1 = 5'($urandom_range(0, 7));
        x.rs2 = 5'($urandom_range(0, 7));
        x.u1  = 1'($urandom_range(0, 1));
        x.u2  = 1'($urandom_range(0, 1));
        x.rd  = 5'($urandom_range(0, 7));
        x.w   = ($urandom_range(0, 9) < 7);
        x.ld  = ($urandom_range(0, 9) < 3);
      end
      drive(k, x, ($urandom_range(0, 15) == 0), ($urandom_range(0, 99) == 0), st);
    end
  endtask

  task automatic cmp(input int k, input exp_t e, input exp_t a);
    checks++;
    if (a === e) passed++;
    else $display("FAIL outputs inst%0d t=%0t: got spc=%b sif=%b bub=%b fl=%b cyc=%0d, want spc=%b sif=%b bub=%b fl=%b cyc=%0d",
                  k, $time, a.spc, a.sif, a.bub, a.fl, a.cyc, e.spc, e.sif, e.bub, e.fl, e.cyc);
  endtask

  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        a = {spc[0], sif[0], bub[0], fl[0], cyc0};
        cmp(0, e, a);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        a = {spc[1], sif[1], bub[1], fl[1], 12'd0, cyc1};
        cmp(1, e, a);
      end
    end
  end

  initial begin
    fork
      prog(0);
      prog(1);
    join
    @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
